// File: rtl/sodor5_commit_checker.sv
// sodor5_commit_checker: lockstep ref/dut writeback comparator with sticky error capture
module sodor5_commit_checker #(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 64,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ref_wb_valid,
  input  logic [4:0]               ref_wb_rd,
  input  logic [31:0]              ref_wb_data,
  input  logic                     dut_wb_valid,
  input  logic [4:0]               dut_wb_rd,
  input  logic [31:0]              dut_wb_data,
  output logic [31:0]              match_count,
  output logic [1:0]               err_code,
  output logic [4:0]               err_ref_rd,
  output logic [31:0]              err_ref_data,
  output logic [4:0]               err_dut_rd,
  output logic [31:0]              err_dut_data,
  output logic [$clog2(DEPTH):0]   ref_pending,
  output logic [$clog2(DEPTH):0]   dut_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic {RUN, ERR} state_t;
  state_t state;
  logic [36:0] ref_mem [DEPTH];
  logic [36:0] dut_mem [DEPTH];
  logic [AW-1:0] ref_rp, ref_wp, dut_rp, dut_wp;
  logic [TW-1:0] tcnt;
  logic [36:0] ref_head, dut_head;
  logic run, ref_ne, dut_ne, ref_push, dut_push, pop, ref_ovf, dut_ovf, ovf, mis, tmo, go;
  always_comb begin
    run = state == RUN;
    ref_ne = ref_pending != '0;
    dut_ne = dut_pending != '0;
    ref_head = ref_ne ? ref_mem[ref_rp] : '0;
    dut_head = dut_ne ? dut_mem[dut_rp] : '0;
    ref_push = run && ref_wb_valid && !(FILTER_X0 && ref_wb_rd == 5'd0);
    dut_push = run && dut_wb_valid && !(FILTER_X0 && dut_wb_rd == 5'd0);
    pop = run && ref_ne && dut_ne;
    ref_ovf = ref_push && ref_pending == FULL && !pop;
    dut_ovf = dut_push && dut_pending == FULL && !pop;
    ovf = ref_ovf || dut_ovf;
    mis = pop && ref_head != dut_head;
    tmo = run && (ref_ne ^ dut_ne) && tcnt == TLAST;
    go = run && !(ovf || mis || tmo);
  end
  always_ff @(posedge clk) begin
    if (go && ref_push) ref_mem[ref_wp] <= {ref_wb_rd, ref_wb_data};
    if (go && dut_push) dut_mem[dut_wp] <= {dut_wb_rd, dut_wb_data};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      ref_rp <= '0;
      ref_wp <= '0;
      dut_rp <= '0;
      dut_wp <= '0;
      ref_pending <= '0;
      dut_pending <= '0;
      tcnt <= '0;
      match_count <= '0;
      err_code <= '0;
      err_ref_rd <= '0;
      err_ref_data <= '0;
      err_dut_rd <= '0;
      err_dut_data <= '0;
    end else if (go) begin
      ref_wp <= ref_wp + AW'(ref_push);
      dut_wp <= dut_wp + AW'(dut_push);
      ref_rp <= ref_rp + AW'(pop);
      dut_rp <= dut_rp + AW'(pop);
      ref_pending <= ref_pending + (AW + 1)'(ref_push) - (AW + 1)'(pop);
      dut_pending <= dut_pending + (AW + 1)'(dut_push) - (AW + 1)'(pop);
      match_count <= match_count + 32'(pop && match_count != '1);
      tcnt <= (ref_ne ^ dut_ne) ? tcnt + 1'b1 : '0;
    end else if (run) begin
      state <= ERR;
      err_code <= ovf ? 2'd3 : mis ? 2'd1 : 2'd2;
      {err_ref_rd, err_ref_data} <= ref_head;
      {err_dut_rd, err_dut_data} <= dut_head;
    end
  end
endmodule

// File: tb/tb_sodor5_commit_checker.sv
// tb_sodor5_commit_checker: randomized and directed checks against a queue-based reference model
module tb_sodor5_commit_checker;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 64;
  localparam bit FILTER_X0 = 1'b1;
  localparam int PW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ref_wb_valid = 1'b0;
  logic [4:0] ref_wb_rd = '0;
  logic [31:0] ref_wb_data = '0;
  logic dut_wb_valid = 1'b0;
  logic [4:0] dut_wb_rd = '0;
  logic [31:0] dut_wb_data = '0;
  logic [31:0] match_count;
  logic [1:0] err_code;
  logic [4:0] err_ref_rd, err_dut_rd;
  logic [31:0] err_ref_data, err_dut_data;
  logic [PW-1:0] ref_pending, dut_pending;
  int n_checks = 0;
  int n_fail = 0;
  logic [36:0] mrq[$];
  logic [36:0] mdq[$];
  bit m_err;
  logic [1:0] m_code;
  logic [31:0] m_match;
  int m_tc;
  logic [36:0] m_eref, m_edut;
  sodor5_commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .FILTER_X0(FILTER_X0)) dut (
    .clk(clk), .reset(reset),
    .ref_wb_valid(ref_wb_valid), .ref_wb_rd(ref_wb_rd), .ref_wb_data(ref_wb_data),
    .dut_wb_valid(dut_wb_valid), .dut_wb_rd(dut_wb_rd), .dut_wb_data(dut_wb_data),
    .match_count(match_count), .err_code(err_code),
    .err_ref_rd(err_ref_rd), .err_ref_data(err_ref_data),
    .err_dut_rd(err_dut_rd), .err_dut_data(err_dut_data),
    .ref_pending(ref_pending), .dut_pending(dut_pending)
  );
  always #5 clk = ~clk;
  task automatic m_step();
    bit rpu, dpu, pop, rov, dov, mis, tmo, one;
    logic [36:0] rh, dh;
    if (reset) begin
      mrq.delete();
      mdq.delete();
      m_err = 0;
      m_code = 0;
      m_match = 0;
      m_tc = 0;
      m_eref = 0;
      m_edut = 0;
      return;
    end
    if (m_err) return;
    rpu = ref_wb_valid && !(FILTER_X0 && ref_wb_rd == 0);
    dpu = dut_wb_valid && !(FILTER_X0 && dut_wb_rd == 0);
    rh = mrq.size() > 0 ? mrq[0] : 37'd0;
    dh = mdq.size() > 0 ? mdq[0] : 37'd0;
    pop = mrq.size() > 0 && mdq.size() > 0;
    one = (mrq.size() > 0) != (mdq.size() > 0);
    rov = rpu && mrq.size() == DEPTH && !pop;
    dov = dpu && mdq.size() == DEPTH && !pop;
    mis = pop && rh != dh;
    tmo = one && m_tc == TIMEOUT - 1;
    if (rov || dov || mis || tmo) begin
      m_err = 1;
      m_code = (rov || dov) ? 2'd3 : (mis ? 2'd1 : 2'd2);
      m_eref = rh;
      m_edut = dh;
      return;
    end
    if (pop) begin
      void'(mrq.pop_front());
      void'(mdq.pop_front());
      if (m_match != 32'hFFFF_FFFF) m_match++;
    end
    if (rpu) mrq.push_back({ref_wb_rd, ref_wb_data});
    if (dpu) mdq.push_back({dut_wb_rd, dut_wb_data});
    m_tc = one ? m_tc + 1 : 0;
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask
  task automatic drive(input bit rv, input logic [4:0] rrd, input logic [31:0] rdat,
                       input bit dv, input logic [4:0] drd, input logic [31:0] ddat);
    ref_wb_valid = rv;
    ref_wb_rd = rrd;
    ref_wb_data = rdat;
    dut_wb_valid = dv;
    dut_wb_rd = drd;
    dut_wb_data = ddat;
    tick();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({match_count, err_code, err_ref_rd, err_ref_data, err_dut_rd, err_dut_data, ref_pending, dut_pending} !== '0) begin
      n_fail++;
      $display("FAIL reset: mc=%0d code=%0d rp=%0d dp=%0d, required all zero", match_count, err_code, ref_pending, dut_pending);
    end
  endtask
  task automatic test_matched();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 5, i, 1, 5, i);
    idle(3);
    n_checks++;
    if (match_count !== 32'd20 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL matched: mc=%0d code=%0d, required 20/0", match_count, err_code);
    end
    n_checks++;
    if (ref_pending !== '0 || dut_pending !== '0) begin
      n_fail++;
      $display("FAIL matched_pending: %0d/%0d, required 0/0", ref_pending, dut_pending);
    end
  endtask
  task automatic test_lead();
    int peak = 0;
    int mpeak = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(i < 10, 9, 32'h100 + i, i >= 3, 9, 32'h100 + i - 3);
      if (int'(ref_pending) > peak) peak = int'(ref_pending);
      if (mrq.size() > mpeak) mpeak = mrq.size();
    end
    idle(3);
    n_checks++;
    if (match_count !== 32'd10 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL lead: mc=%0d code=%0d, required 10/0", match_count, err_code);
    end
    n_checks++;
    if (peak != mpeak || peak < 3) begin
      n_fail++;
      $display("FAIL lead_peak: got %0d, required %0d", peak, mpeak);
    end
  endtask
  task automatic test_mismatch();
    logic [PW-1:0] rp, dp;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 7, i < 3 ? i : 32'h1234, 1, 7, i < 3 ? i : 32'h1235);
    idle(2);
    n_checks++;
    if (err_code !== 2'd1 || err_ref_rd !== 5'd7 || err_ref_data !== 32'h1234 ||
        err_dut_rd !== 5'd7 || err_dut_data !== 32'h1235) begin
      n_fail++;
      $display("FAIL mismatch: code=%0d ref=%0d/%h dut=%0d/%h, required 1 7/1234 7/1235",
               err_code, err_ref_rd, err_ref_data, err_dut_rd, err_dut_data);
    end
    rp = ref_pending;
    dp = dut_pending;
    for (int i = 0; i < 6; i++) drive(1, 3, i, 1, 3, i + 1);
    n_checks++;
    if (match_count !== 32'd3 || err_code !== 2'd1 || err_ref_data !== 32'h1234 ||
        err_dut_data !== 32'h1235 || ref_pending !== rp || dut_pending !== dp) begin
      n_fail++;
      $display("FAIL mismatch_frozen: mc=%0d code=%0d pend=%0d/%0d, required 3 1 %0d/%0d",
               match_count, err_code, ref_pending, dut_pending, rp, dp);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 1, i, 0, 0, 0);
    idle(1);
    n_checks++;
    if (err_code !== 2'd3 || ref_pending !== PW'(8) || dut_pending !== '0) begin
      n_fail++;
      $display("FAIL overflow: code=%0d rp=%0d dp=%0d, required 3 8 0", err_code, ref_pending, dut_pending);
    end
  endtask
  task automatic test_reset_in_err();
    n_checks++;
    if (err_code === 2'd0) begin
      n_fail++;
      $display("FAIL err_before_reset: code=%0d, required nonzero", err_code);
    end
    do_reset();
    n_checks++;
    if ({match_count, err_code, err_ref_rd, err_ref_data, err_dut_rd, err_dut_data, ref_pending, dut_pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_err: mc=%0d code=%0d rp=%0d dp=%0d, required all zero", match_count, err_code, ref_pending, dut_pending);
    end
  endtask
  task automatic test_timeout();
    int k = 0;
    do_reset();
    drive(1, 4, 32'hABCD, 0, 0, 0);
    n_checks++;
    if (ref_pending !== PW'(1)) begin
      n_fail++;
      $display("FAIL timeout_head: rp=%0d, required 1", ref_pending);
    end
    while (err_code === 2'd0 && k < TIMEOUT + 10) begin
      idle(1);
      k++;
    end
    n_checks++;
    if (k != TIMEOUT || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL timeout: after %0d cycles code=%0d, required %0d cycles code 2", k, err_code, TIMEOUT);
    end
    n_checks++;
    if (err_ref_rd !== 5'd4 || err_ref_data !== 32'hABCD || err_dut_rd !== '0 || err_dut_data !== '0) begin
      n_fail++;
      $display("FAIL timeout_err: ref=%0d/%h dut=%0d/%h, required 4/abcd 0/0", err_ref_rd, err_ref_data, err_dut_rd, err_dut_data);
    end
  endtask
  task automatic test_filter();
    do_reset();
    for (int i = 0; i < 12; i++) drive(1, 0, i, 1, 0, ~i);
    idle(2);
    n_checks++;
    if (match_count !== '0 || err_code !== 2'd0 || ref_pending !== '0 || dut_pending !== '0) begin
      n_fail++;
      $display("FAIL filter: mc=%0d code=%0d pend=%0d/%0d, required 0 0 0/0", match_count, err_code, ref_pending, dut_pending);
    end
  endtask
  task automatic test_random();
    logic [36:0] ev[40];
    for (int r = 0; r < 10; r++) begin
      int ri = 0;
      int di = 0;
      do_reset();
      for (int e = 0; e < 40; e++) ev[e] = {5'($urandom_range(0, 3)), 32'($urandom_range(0, 255))};
      for (int c = 0; c < 300 && !m_err && (ri < 40 || di < 40 || mrq.size() > 0); c++) begin
        bit rv = ri < 40 && $urandom_range(0, 9) < (r % 2 ? 8 : 5);
        bit dv = di < 40 && $urandom_range(0, 9) < 6;
        logic [36:0] re = rv ? ev[ri] : 37'd0;
        logic [36:0] de = dv ? ev[di] ^ 37'($urandom_range(0, 39) == 0) : 37'd0;
        ri += int'(rv);
        di += int'(dv);
        drive(rv, re[36:32], re[31:0], dv, de[36:32], de[31:0]);
        n_checks++;
        if (match_count !== m_match || err_code !== m_code || ref_pending !== PW'(mrq.size()) ||
            dut_pending !== PW'(mdq.size()) || {err_ref_rd, err_ref_data} !== m_eref ||
            {err_dut_rd, err_dut_data} !== m_edut) begin
          n_fail++;
          $display("FAIL random r%0d c%0d: mc=%0d code=%0d pend=%0d/%0d eref=%h edut=%h, required %0d %0d %0d/%0d %h %h",
                   r, c, match_count, err_code, ref_pending, dut_pending, {err_ref_rd, err_ref_data},
                   {err_dut_rd, err_dut_data}, m_match, m_code, mrq.size(), mdq.size(), m_eref, m_edut);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_matched();
    test_lead();
    test_mismatch();
    test_reset_in_err();
    test_overflow();
    test_reset_in_err();
    test_timeout();
    test_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
